control_unit: RTL and testbench

//  Multi-cycle instruction sequencer directly upstream of mainRegister.
//  - Accepts 8-bit instructions over a valid/ready handshake and decodes them.
//  - Drives the register file's raAddress/rbAddress/regWrite, the ALU opcode,
//    and the write-back select that steers dataIn (ALU result or immediate).
//  - One instruction in flight at a time; no pipelining.

---
 rtl/control_unit_if.sv | 32 +++
 rtl/control_unit.sv | 110 +++++++++++
 tb/tb_control_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Instruction/register-file bus between the byte source and the control unit.
interface control_unit_if;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned OP_W    = 3;

    logic [INSTR_W-1:0] instr_in;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  raAddress;
    logic [ADDR_W-1:0]  rbAddress;
    logic               regWrite;
    logic [OP_W-1:0]    aluOp;
    logic               wbSel;
    logic [INSTR_W-1:0] immData;
    logic               halted;
    logic               illegal;

    // Byte source side: offers instructions, observes decoded controls.
    modport master (
        output instr_in, instr_valid,
        input  instr_ready, raAddress, rbAddress, regWrite, aluOp,
               wbSel, immData, halted, illegal
    );

    // Control unit side.
    modport slave (
        input  instr_in, instr_valid,
        output instr_ready, raAddress, rbAddress, regWrite, aluOp,
               wbSel, immData, halted, illegal
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer feeding the register file and ALU.
// One instruction in flight; all outputs registered.
module control_unit #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input logic           clk,
    input logic           reset,
    control_unit_if.slave bus
);
    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OPC_NOP  = 4'd0;
    localparam logic [OPC_W-1:0] OPC_MOV  = 4'd6;
    localparam logic [OPC_W-1:0] OPC_LDI  = 4'd7;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WRITE,
        S_IMM,
        S_HALT
    } state_t;

    state_t           state;
    logic [OPC_W-1:0] op_q;

    // Sequencer: state, latched opcode and every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_FETCH;
            op_q            <= '0;
            bus.instr_ready <= 1'b1;
            bus.raAddress   <= '0;
            bus.rbAddress   <= '0;
            bus.regWrite    <= 1'b0;
            bus.aluOp       <= '0;
            bus.wbSel       <= 1'b0;
            bus.immData     <= '0;
            bus.halted      <= 1'b0;
            bus.illegal     <= 1'b0;
        end else begin
            bus.regWrite <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        op_q          <= bus.instr_in[7:4];
                        bus.raAddress <= bus.instr_in[3:2];
                        bus.rbAddress <= bus.instr_in[1:0];
                        if (bus.instr_in[7:4] == OPC_LDI) begin
                            state <= S_IMM;
                        end else begin
                            state           <= S_DECODE;
                            bus.instr_ready <= 1'b0;
                        end
                    end
                end
                S_DECODE: begin
                    if (op_q == OPC_NOP) begin
                        state           <= S_FETCH;
                        bus.instr_ready <= 1'b1;
                    end else if (op_q == OPC_HALT) begin
                        state      <= S_HALT;
                        bus.halted <= 1'b1;
                    end else if (op_q <= OPC_MOV) begin
                        // ADD..XOR map to aluOp 0..4, MOV maps to PASSB (5).
                        state     <= S_EXEC;
                        bus.aluOp <= 3'(op_q - 4'd1);
                    end else begin
                        bus.illegal <= 1'b1;
                        if (HALT_ON_ILLEGAL) begin
                            state      <= S_HALT;
                            bus.halted <= 1'b1;
                        end else begin
                            state           <= S_FETCH;
                            bus.instr_ready <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    state        <= S_WRITE;
                    bus.regWrite <= 1'b1;
                    bus.wbSel    <= 1'b0;
                end
                S_WRITE: begin
                    state           <= S_FETCH;
                    bus.instr_ready <= 1'b1;
                end
                S_IMM: begin
                    if (bus.instr_valid) begin
                        state           <= S_WRITE;
                        bus.immData     <= bus.instr_in;
                        bus.regWrite    <= 1'b1;
                        bus.wbSel       <= 1'b1;
                        bus.instr_ready <= 1'b0;
                    end
                end
                S_HALT: begin
                    bus.instr_ready <= 1'b0;
                    bus.halted      <= 1'b1;
                end
                default: begin
                    state           <= S_FETCH;
                    bus.instr_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit (both illegal-opcode policies).
module tb_control_unit;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    control_unit_if i0 ();
    control_unit_if i1 ();

    control_unit #(.HALT_ON_ILLEGAL(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(i0));
    control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(i1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        i0.instr_valid = 1'b0;
        i1.instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            got = {i0.instr_ready, i0.raAddress, i0.rbAddress, i0.regWrite, i0.aluOp,
                   i0.wbSel, i0.immData, i0.halted, i0.illegal};
            checks++;
            if (got !== 20'h80000) begin
                failures++;
                $display("FAIL reset_hold cyc%0d got=%h exp=80000", c, got);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_add();
        i0.instr_in = 8'h16; i0.instr_valid = 1'b1;
        @(negedge clk);
        i0.instr_valid = 1'b0;
        checks++;
        if ({i0.raAddress, i0.rbAddress, i0.regWrite, i0.instr_ready} !== 6'b01_10_0_0) begin
            failures++;
            $display("FAIL add_cyc1 got ra=%0d rb=%0d wr=%0b rdy=%0b exp ra=1 rb=2 wr=0 rdy=0",
                     i0.raAddress, i0.rbAddress, i0.regWrite, i0.instr_ready);
        end
        @(negedge clk);
        checks++;
        if ({i0.regWrite, i0.aluOp} !== 4'b0_000) begin
            failures++;
            $display("FAIL add_cyc2 got wr=%0b op=%0d exp wr=0 op=0", i0.regWrite, i0.aluOp);
        end
        @(negedge clk);
        checks++;
        if ({i0.regWrite, i0.wbSel, i0.aluOp, i0.raAddress, i0.rbAddress} !== 9'b1_0_000_01_10) begin
            failures++;
            $display("FAIL add_cyc3 got wr=%0b wb=%0b op=%0d ra=%0d rb=%0d exp wr=1 wb=0 op=0 ra=1 rb=2",
                     i0.regWrite, i0.wbSel, i0.aluOp, i0.raAddress, i0.rbAddress);
        end
        @(negedge clk);
        checks++;
        if ({i0.regWrite, i0.instr_ready} !== 2'b01) begin
            failures++;
            $display("FAIL add_cyc4 got wr=%0b rdy=%0b exp wr=0 rdy=1", i0.regWrite, i0.instr_ready);
        end
    endtask

    task automatic test_ldi();
        // Back-to-back immediate.
        i0.instr_in = 8'h7C; i0.instr_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({i0.instr_ready, i0.regWrite} !== 2'b10) begin
            failures++;
            $display("FAIL ldi_imm_wait got rdy=%0b wr=%0b exp rdy=1 wr=0", i0.instr_ready, i0.regWrite);
        end
        i0.instr_in = 8'h2D;
        @(negedge clk);
        i0.instr_valid = 1'b0;
        checks++;
        if ({i0.regWrite, i0.wbSel, i0.raAddress, i0.immData} !== {1'b1, 1'b1, 2'd3, 8'h2D}) begin
            failures++;
            $display("FAIL ldi_write got wr=%0b wb=%0b ra=%0d imm=%h exp wr=1 wb=1 ra=3 imm=2d",
                     i0.regWrite, i0.wbSel, i0.raAddress, i0.immData);
        end
        @(negedge clk);
        checks++;
        if ({i0.regWrite, i0.instr_ready} !== 2'b01) begin
            failures++;
            $display("FAIL ldi_done got wr=%0b rdy=%0b exp wr=0 rdy=1", i0.regWrite, i0.instr_ready);
        end
        // Immediate after a 5-cycle gap.
        i0.instr_in = 8'h74; i0.instr_valid = 1'b1;
        @(negedge clk);
        i0.instr_valid = 1'b0;
        i0.instr_in    = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({i0.instr_ready, i0.regWrite} !== 2'b10) begin
                failures++;
                $display("FAIL ldi_gap cyc%0d got rdy=%0b wr=%0b exp rdy=1 wr=0",
                         c, i0.instr_ready, i0.regWrite);
            end
            @(negedge clk);
        end
        i0.instr_in = 8'hA5; i0.instr_valid = 1'b1;
        @(negedge clk);
        i0.instr_valid = 1'b0;
        checks++;
        if ({i0.regWrite, i0.wbSel, i0.raAddress, i0.immData} !== {1'b1, 1'b1, 2'd1, 8'hA5}) begin
            failures++;
            $display("FAIL ldi_gap_write got wr=%0b wb=%0b ra=%0d imm=%h exp wr=1 wb=1 ra=1 imm=a5",
                     i0.regWrite, i0.wbSel, i0.raAddress, i0.immData);
        end
        @(negedge clk);
    endtask

    task automatic test_alu_ops();
        logic [7:0] vec [6] = '{8'h16, 8'h2B, 8'h31, 8'h4E, 8'h55, 8'h62};
        logic [2:0] exp_op [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [1:0] exp_ra [6] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
        logic [1:0] exp_rb [6] = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2};
        for (int k = 0; k < 6; k++) begin
            i0.instr_in = vec[k]; i0.instr_valid = 1'b1;
            @(negedge clk);
            i0.instr_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ({i0.regWrite, i0.wbSel, i0.aluOp, i0.raAddress, i0.rbAddress} !==
                {1'b1, 1'b0, exp_op[k], exp_ra[k], exp_rb[k]}) begin
                failures++;
                $display("FAIL alu_%h got wr=%0b wb=%0b op=%0d ra=%0d rb=%0d exp wr=1 wb=0 op=%0d ra=%0d rb=%0d",
                         vec[k], i0.regWrite, i0.wbSel, i0.aluOp, i0.raAddress, i0.rbAddress,
                         exp_op[k], exp_ra[k], exp_rb[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        i0.instr_in = 8'h9A; i0.instr_valid = 1'b1;
        i1.instr_in = 8'h9A; i1.instr_valid = 1'b1;
        @(negedge clk);
        i0.instr_valid = 1'b0;
        i1.instr_valid = 1'b0;
        checks++;
        if ({i0.illegal, i0.regWrite, i1.illegal, i1.regWrite} !== 4'b0000) begin
            failures++;
            $display("FAIL illegal_cyc1 got il0=%0b wr0=%0b il1=%0b wr1=%0b exp all 0",
                     i0.illegal, i0.regWrite, i1.illegal, i1.regWrite);
        end
        @(negedge clk);
        checks++;
        if ({i0.illegal, i0.instr_ready, i0.halted, i0.regWrite} !== 4'b1100) begin
            failures++;
            $display("FAIL illegal_nop_policy got il=%0b rdy=%0b hlt=%0b wr=%0b exp il=1 rdy=1 hlt=0 wr=0",
                     i0.illegal, i0.instr_ready, i0.halted, i0.regWrite);
        end
        checks++;
        if ({i1.illegal, i1.instr_ready, i1.halted, i1.regWrite} !== 4'b1010) begin
            failures++;
            $display("FAIL illegal_halt_policy got il=%0b rdy=%0b hlt=%0b wr=%0b exp il=1 rdy=0 hlt=1 wr=0",
                     i1.illegal, i1.instr_ready, i1.halted, i1.regWrite);
        end
        i0.instr_in = 8'h00; i0.instr_valid = 1'b1;
        i1.instr_in = 8'h16; i1.instr_valid = 1'b1;
        @(negedge clk);
        i0.instr_valid = 1'b0;
        checks++;
        if ({i0.instr_ready, i0.illegal} !== 2'b01) begin
            failures++;
            $display("FAIL illegal_refetch got rdy=%0b il=%0b exp rdy=0 il=1", i0.instr_ready, i0.illegal);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({i1.halted, i1.instr_ready, i1.regWrite} !== 3'b100) begin
                failures++;
                $display("FAIL illegal_halt_hold cyc%0d got hlt=%0b rdy=%0b wr=%0b exp hlt=1 rdy=0 wr=0",
                         c, i1.halted, i1.instr_ready, i1.regWrite);
            end
        end
        i1.instr_valid = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        i0.instr_in = 8'hF0; i0.instr_valid = 1'b1;
        @(negedge clk);
        i0.instr_in = 8'h16;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({i0.halted, i0.instr_ready, i0.regWrite, i0.illegal} !== 4'b1000) begin
                failures++;
                $display("FAIL halt_hold cyc%0d got hlt=%0b rdy=%0b wr=%0b il=%0b exp hlt=1 rdy=0 wr=0 il=0",
                         c, i0.halted, i0.instr_ready, i0.regWrite, i0.illegal);
            end
        end
        do_reset();
        checks++;
        if ({i0.halted, i0.instr_ready} !== 2'b01) begin
            failures++;
            $display("FAIL halt_reset got hlt=%0b rdy=%0b exp hlt=0 rdy=1", i0.halted, i0.instr_ready);
        end
        i0.instr_in = 8'h16; i0.instr_valid = 1'b1;
        @(negedge clk);
        i0.instr_valid = 1'b0;
        checks++;
        if ({i0.instr_ready, i0.raAddress, i0.rbAddress} !== 5'b0_01_10) begin
            failures++;
            $display("FAIL halt_refetch got rdy=%0b ra=%0d rb=%0d exp rdy=0 ra=1 rb=2",
                     i0.instr_ready, i0.raAddress, i0.rbAddress);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [19:0] got;
        i0.instr_in = 8'h24; i0.instr_valid = 1'b1;
        @(negedge clk);
        i0.instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({i0.aluOp, i0.regWrite} !== 4'b001_0) begin
            failures++;
            $display("FAIL sub_exec got op=%0d wr=%0b exp op=1 wr=0", i0.aluOp, i0.regWrite);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        got = {i0.instr_ready, i0.raAddress, i0.rbAddress, i0.regWrite, i0.aluOp,
               i0.wbSel, i0.immData, i0.halted, i0.illegal};
        checks++;
        if (got !== 20'h80000) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%h exp=80000", got);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (i0.regWrite !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_nowrite cyc%0d got wr=%0b exp wr=0", c, i0.regWrite);
            end
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        i0.instr_in    = 8'h00;
        i0.instr_valid = 1'b0;
        i1.instr_in    = 8'h00;
        i1.instr_valid = 1'b0;
        test_reset();
        test_add();
        test_ldi();
        test_alu_ops();
        test_illegal();
        test_halt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
